// File: rtl/lcd_frame_writer.sv
// LCD frame writer: PPU pixel stream into a double-buffered frame buffer.
// Display bank flips only when a complete, clean frame was written.
module lcd_frame_writer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 144,
    parameter int ADDR_W = 16
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              lcd_on_in,
    input  logic [1:0]        pixel_in,
    input  logic              pixel_valid_in,
    input  logic              hblank_in,
    input  logic              vblank_in,
    output logic [ADDR_W-1:0] wr_addr_out,
    output logic [1:0]        wr_data_out,
    output logic              wr_en_out,
    output logic              disp_bank_out,
    output logic              frame_done_out,
    output logic [7:0]        frame_count_out,
    output logic              frame_err_out
);

    typedef enum logic [1:0] {
        S_SYNC   = 2'd0,
        S_DRAW   = 2'd1,
        S_VBLANK = 2'd2
    } state_t;

    localparam logic [7:0]        W8       = 8'(WIDTH);
    localparam logic [7:0]        H8       = 8'(HEIGHT);
    localparam logic [ADDR_W-1:0] BANK_OFF = ADDR_W'(WIDTH * HEIGHT);

    // y*WIDTH as a sum of shifted copies of y, one per set bit of WIDTH
    function automatic logic [ADDR_W-1:0] line_base(input logic [7:0] y);
        logic [ADDR_W-1:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (WIDTH[i]) acc = acc + (ADDR_W'(y) << i);
        end
        return acc;
    endfunction

    state_t            state_q, state_d;
    logic [7:0]        x_q, x_d, y_q, y_d;
    logic              bad_q, bad_d;
    logic              hb_prev_q, hb_prev_d, vb_prev_q, vb_prev_d;
    logic              disp_q, disp_d;
    logic              done_q, done_d;
    logic [7:0]        count_q, count_d;
    logic              err_q, err_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [1:0]        wr_data_q, wr_data_d;

    logic              hb_rise, vb_rise, vb_fall;
    logic              accept, drop;
    logic [7:0]        x_px;
    logic [ADDR_W-1:0] pix_addr;

    assign hb_rise = hblank_in & ~hb_prev_q;
    assign vb_rise = vblank_in & ~vb_prev_q;
    assign vb_fall = ~vblank_in & vb_prev_q;

    assign accept = lcd_on_in && (state_q == S_DRAW) && pixel_valid_in
                    && (x_q < W8) && (y_q < H8);
    assign drop   = lcd_on_in && (state_q == S_DRAW) && pixel_valid_in
                    && !accept;
    assign x_px   = accept ? x_q + 8'd1 : x_q;

    // write bank is always the one not being displayed
    assign pix_addr = (disp_q ? '0 : BANK_OFF) + line_base(y_q)
                      + ADDR_W'(x_q);

    // FSM state register
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state_q <= S_SYNC;
        else        state_q <= state_d;
    end

    // FSM next state; display-off forces resynchronisation
    always_comb begin
        state_d = state_q;
        if (!lcd_on_in) begin
            state_d = S_SYNC;
        end else begin
            unique case (state_q)
                S_SYNC:   if (vb_fall) state_d = S_DRAW;
                S_DRAW:   if (vb_rise) state_d = S_VBLANK;
                S_VBLANK: if (vb_fall) state_d = S_DRAW;
                default:  state_d = S_SYNC;
            endcase
        end
    end

    // FSM outputs: pixel writes, line/frame bookkeeping and commit
    always_comb begin
        x_d       = x_q;
        y_d       = y_q;
        bad_d     = bad_q;
        disp_d    = disp_q;
        done_d    = 1'b0;
        count_d   = count_q;
        err_d     = err_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        hb_prev_d = hblank_in;
        vb_prev_d = vblank_in;
        if (lcd_on_in) begin
            if (state_q == S_DRAW) begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = pix_addr;
                    wr_data_d = pixel_in;
                    x_d       = x_px;
                end
                if (drop) bad_d = 1'b1;
                // a pixel in the same cycle still belongs to this line
                if (hb_rise) begin
                    if (x_px != W8) bad_d = 1'b1;
                    x_d = 8'd0;
                    if (y_q < H8) y_d = y_q + 8'd1;
                end
                if (vb_rise) begin
                    if ((y_d == H8) && !bad_d) begin
                        disp_d  = ~disp_q;
                        done_d  = 1'b1;
                        count_d = count_q + 8'd1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end else if (vb_fall) begin
                x_d   = 8'd0;
                y_d   = 8'd0;
                bad_d = 1'b0;
            end
        end
    end

    // datapath and status registers
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            x_q       <= 8'd0;
            y_q       <= 8'd0;
            bad_q     <= 1'b0;
            hb_prev_q <= 1'b0;
            vb_prev_q <= 1'b0;
            disp_q    <= 1'b0;
            done_q    <= 1'b0;
            count_q   <= 8'd0;
            err_q     <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= 2'd0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            bad_q     <= bad_d;
            hb_prev_q <= hb_prev_d;
            vb_prev_q <= vb_prev_d;
            disp_q    <= disp_d;
            done_q    <= done_d;
            count_q   <= count_d;
            err_q     <= err_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wr_addr_out     = wr_addr_q;
    assign wr_data_out     = wr_data_q;
    assign wr_en_out       = wr_en_q;
    assign disp_bank_out   = disp_q;
    assign frame_done_out  = done_q;
    assign frame_count_out = count_q;
    assign frame_err_out   = err_q;

endmodule
